// File: rtl/wash_controller_pkg.sv
`default_nettype none
//==============================================================================
// Module   : wash_controller_pkg
// Brief    : State encoding, timer terminal counts, load codes and decode helpers
// Revision : 1.0 - initial release
//==============================================================================
package wash_controller_pkg;

    localparam logic [3:0] c_ST_IDLE  = 4'd0;
    localparam logic [3:0] c_ST_LOCK  = 4'd1;
    localparam logic [3:0] c_ST_FILL  = 4'd2;
    localparam logic [3:0] c_ST_WASH  = 4'd3;
    localparam logic [3:0] c_ST_DRAIN = 4'd4;
    localparam logic [3:0] c_ST_RINSE = 4'd5;
    localparam logic [3:0] c_ST_SPIN  = 4'd6;
    localparam logic [3:0] c_ST_DONE  = 4'd7;
    localparam logic [3:0] c_ST_ABORT = 4'd8;
    localparam logic [3:0] c_ST_FAULT = 4'd9;

    localparam logic [3:0] c_TC_D = 4'd1;
    localparam logic [3:0] c_TC_F = 4'd2;
    localparam logic [3:0] c_TC_R = 4'd4;
    localparam logic [3:0] c_TC_S = 4'd8;

    localparam logic [1:0] c_LOAD_SMALL   = 2'd0;
    localparam logic [1:0] c_LOAD_MEDIUM  = 2'd1;
    localparam logic [1:0] c_LOAD_LARGE   = 2'd2;
    localparam logic [1:0] c_LOAD_ILLEGAL = 2'd3;

    typedef struct packed {
        logic door_lock;
        logic valve_in;
        logic agitate;
        logic pump_out;
        logic spin;
    } act_t;

    function automatic logic is_timed(input logic [3:0] st);
        return ((st >= c_ST_LOCK) && (st <= c_ST_SPIN)) || (st == c_ST_ABORT);
    endfunction

    // Terminal count at which the timer raises tw for a given load size.
    function automatic logic [3:0] wash_tc(input logic [1:0] ld);
        logic [3:0] tc;
        case (ld)
            c_LOAD_SMALL:  tc = c_TC_F;
            c_LOAD_MEDIUM: tc = c_TC_R;
            c_LOAD_LARGE:  tc = c_TC_S;
            default:       tc = c_TC_S;
        endcase
        return tc;
    endfunction

    function automatic act_t state_act(input logic [3:0] st);
        act_t a;
        a = '0;
        case (st)
            c_ST_LOCK:  a.door_lock = 1'b1;
            c_ST_FILL:  begin a.door_lock = 1'b1; a.valve_in = 1'b1; end
            c_ST_WASH:  begin a.door_lock = 1'b1; a.agitate  = 1'b1; end
            c_ST_DRAIN: begin a.door_lock = 1'b1; a.pump_out = 1'b1; end
            c_ST_RINSE: begin a.door_lock = 1'b1; a.valve_in = 1'b1; a.agitate = 1'b1; end
            c_ST_SPIN:  begin a.door_lock = 1'b1; a.pump_out = 1'b1; a.spin = 1'b1; end
            c_ST_ABORT: begin a.door_lock = 1'b1; a.pump_out = 1'b1; end
            default:    a = '0;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wash_controller_wdog.sv
`default_nettype none
//==============================================================================
// Module   : wash_controller_wdog
// Brief    : Per-phase watchdog counter; expire flags the last allowed cycle
// Revision : 1.0 - initial release
//==============================================================================
module wash_controller_wdog #(
    parameter int WDOG_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int              c_W    = $clog2(WDOG_MAX);
    localparam logic [c_W-1:0]  c_LAST = c_W'(WDOG_MAX - 1);

    logic [c_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Asserted one cycle early so the registered FAULT lands exactly WDOG_MAX cycles after entry.
    assign expire = enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/wash_controller.sv
`default_nettype none
//==============================================================================
// Module   : wash_controller
// Brief    : Washing-machine sequencer driven by phase-timer events, with abort and watchdog
// Revision : 1.0 - initial release
//==============================================================================
module wash_controller
    import wash_controller_pkg::*;
#(
    parameter int RINSES   = 1,
    parameter int WDOG_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] load_sel,
    input  logic       td,
    input  logic       tf,
    input  logic       tr,
    input  logic       ts,
    input  logic       tw,
    output logic       timer_reset,
    output logic [1:0] load,
    output logic       door_lock,
    output logic       valve_in,
    output logic       agitate,
    output logic       pump_out,
    output logic       spin,
    output logic       done,
    output logic       fault
);
    localparam logic [2:0] c_RINSES = 3'(RINSES);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [2:0] r_rinse_cnt;
    logic       w_rinse_inc;
    logic       w_entry;
    logic       w_expire;
    logic       w_ev_ok;
    logic       w_in_run;
    logic       w_timed;
    logic       w_done;
    logic       w_fault;
    act_t       w_act;

    // The timer count is stale during the entry cycle, so events are masked then.
    assign w_ev_ok  = ~timer_reset;
    assign w_in_run = (r_state >= c_ST_LOCK) && (r_state <= c_ST_SPIN);
    assign w_timed  = is_timed(r_state);

    wash_controller_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_entry),
        .enable (w_timed),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_rinse_cnt <= 3'd0;
            timer_reset <= 1'b0;
            load        <= 2'd0;
            door_lock   <= 1'b0;
            valve_in    <= 1'b0;
            agitate     <= 1'b0;
            pump_out    <= 1'b0;
            spin        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            r_state     <= w_next;
            timer_reset <= w_entry;
            if ((r_state == c_ST_IDLE) && (w_next == c_ST_LOCK)) begin
                load <= load_sel;
            end
            if (w_entry && (w_next == c_ST_LOCK)) begin
                r_rinse_cnt <= 3'd0;
            end else if (w_rinse_inc) begin
                r_rinse_cnt <= r_rinse_cnt + 3'd1;
            end
            door_lock <= w_act.door_lock;
            valve_in  <= w_act.valve_in;
            agitate   <= w_act.agitate;
            pump_out  <= w_act.pump_out;
            spin      <= w_act.spin;
            done      <= w_done;
            fault     <= w_fault;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_rinse_inc = 1'b0;
        case (r_state)
            c_ST_IDLE:  if (start && !abort && (load_sel != c_LOAD_ILLEGAL)) w_next = c_ST_LOCK;
            c_ST_LOCK:  if (td && w_ev_ok) w_next = c_ST_FILL;
            c_ST_FILL:  if (tf && w_ev_ok) w_next = c_ST_WASH;
            c_ST_WASH:  if (tw && w_ev_ok) w_next = c_ST_DRAIN;
            c_ST_DRAIN: begin
                if (tf && w_ev_ok) begin
                    if (r_rinse_cnt < c_RINSES) begin
                        w_next      = c_ST_RINSE;
                        w_rinse_inc = 1'b1;
                    end else begin
                        w_next = c_ST_SPIN;
                    end
                end
            end
            c_ST_RINSE: if (tr && w_ev_ok) w_next = c_ST_DRAIN;
            c_ST_SPIN:  if (ts && w_ev_ok) w_next = c_ST_DONE;
            c_ST_DONE:  if (!start) w_next = c_ST_IDLE;
            c_ST_ABORT: if (tf && w_ev_ok) w_next = c_ST_IDLE;
            c_ST_FAULT: w_next = c_ST_FAULT;
            default:    w_next = c_ST_IDLE;
        endcase
        if (w_in_run && abort) begin
            w_next      = c_ST_ABORT;
            w_rinse_inc = 1'b0;
        end
        if (w_expire) begin
            w_next      = c_ST_FAULT;
            w_rinse_inc = 1'b0;
        end
    end

    always_comb begin
        w_act   = state_act(w_next);
        w_done  = (w_next == c_ST_DONE);
        w_fault = (w_next == c_ST_FAULT);
        w_entry = is_timed(w_next) && (w_next != r_state);
    end

endmodule
`default_nettype wire

// File: tb/tb_wash_controller.sv
`default_nettype none
//==============================================================================
// Module   : tb_wash_controller
// Brief    : Bench for wash_controller with a behavioural phase timer and timeline model
// Revision : 1.0 - initial release
//==============================================================================
module tb_wash_controller;
    import wash_controller_pkg::*;

    localparam int WDOG = 16;

    localparam logic [4:0] A_OFF   = 5'b00000;
    localparam logic [4:0] A_LOCK  = 5'b10000;
    localparam logic [4:0] A_FILL  = 5'b11000;
    localparam logic [4:0] A_WASH  = 5'b10100;
    localparam logic [4:0] A_DRAIN = 5'b10010;
    localparam logic [4:0] A_RINSE = 5'b11100;
    localparam logic [4:0] A_SPIN  = 5'b10011;
    localparam logic [4:0] A_ABORT = 5'b10010;

    logic       clk = 1'b0;
    logic       reset;
    logic       start    [2];
    logic       abort    [2];
    logic [1:0] load_sel [2];
    logic       td [2], tf [2], tr [2], ts [2], tw [2];
    logic       timer_reset [2];
    logic [1:0] load [2];
    logic       door_lock [2], valve_in [2], agitate [2], pump_out [2], spin [2];
    logic       done [2], fault [2];
    logic [7:0] tcnt [2];
    logic       sup_tf [2];

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    wash_controller #(.RINSES(1), .WDOG_MAX(WDOG)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]), .load_sel(load_sel[0]),
        .td(td[0]), .tf(tf[0]), .tr(tr[0]), .ts(ts[0]), .tw(tw[0]),
        .timer_reset(timer_reset[0]), .load(load[0]), .door_lock(door_lock[0]),
        .valve_in(valve_in[0]), .agitate(agitate[0]), .pump_out(pump_out[0]), .spin(spin[0]),
        .done(done[0]), .fault(fault[0]));

    wash_controller #(.RINSES(0), .WDOG_MAX(WDOG)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]), .load_sel(load_sel[1]),
        .td(td[1]), .tf(tf[1]), .tr(tr[1]), .ts(ts[1]), .tw(tw[1]),
        .timer_reset(timer_reset[1]), .load(load[1]), .door_lock(door_lock[1]),
        .valve_in(valve_in[1]), .agitate(agitate[1]), .pump_out(pump_out[1]), .spin(spin[1]),
        .done(done[1]), .fault(fault[1]));

    // Phase timer: free-running saturating count, cleared by timer_reset.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || timer_reset[i]) tcnt[i] <= 8'd0;
            else if (tcnt[i] != 8'hff)   tcnt[i] <= tcnt[i] + 8'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            td[i] = (tcnt[i] == 8'(c_TC_D));
            tf[i] = (tcnt[i] == 8'(c_TC_F)) && !sup_tf[i];
            tr[i] = (tcnt[i] == 8'(c_TC_R));
            ts[i] = (tcnt[i] == 8'(c_TC_S));
            tw[i] = (tcnt[i] == 8'(wash_tc(load[i])));
        end
    end

    function automatic logic [4:0] act_of(input int i);
        return {door_lock[i], valve_in[i], agitate[i], pump_out[i], spin[i]};
    endfunction

    function automatic logic [9:0] all_out(input int i);
        return {timer_reset[i], load[i], act_of(i), done[i], fault[i]};
    endfunction

    function automatic void push(input logic [4:0] a, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == 0), a});
    endfunction

    // Expected per-cycle {entry, actuators} from LOCK entry up to the cycle before DONE.
    function automatic void build(input int rinses, input int ld);
        exp_q.delete();
        push(A_LOCK, 3);
        push(A_FILL, 4);
        push(A_WASH, (2 << ld) + 2);
        push(A_DRAIN, 4);
        for (int r = 0; r < rinses; r++) begin
            push(A_RINSE, 6);
            push(A_DRAIN, 4);
        end
        push(A_SPIN, 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; load_sel[i] = 2'd0; sup_tf[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (all_out(i) !== 10'b0) begin
                bad++;
                $display("FAIL reset_state[%0d]: got %b expected %b", i, all_out(i), 10'b0);
            end
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (all_out(i) !== 10'b0) begin
                bad++;
                $display("FAIL reset_release[%0d]: got %b expected %b", i, all_out(i), 10'b0);
            end
        end
    endtask

    task automatic test_illegal_load();
        start[0] = 1'b1;
        load_sel[0] = c_LOAD_ILLEGAL;
        repeat (5) begin
            tick();
            total++;
            if (all_out(0) !== 10'b0) begin
                bad++;
                $display("FAIL illegal_load: got %b expected %b", all_out(0), 10'b0);
            end
        end
        start[0] = 1'b0;
        load_sel[0] = 2'd0;
        tick();
    endtask

    task automatic test_normal(input int i, input int rinses, input int ld);
        int hold;
        build(rinses, ld);
        start[i] = 1'b1;
        load_sel[i] = 2'(ld);
        tick();
        for (int k = 0; k < exp_q.size(); k++) begin
            total++;
            if ({timer_reset[i], act_of(i)} !== exp_q[k]) begin
                bad++;
                $display("FAIL run[%0d] ld=%0d cycle %0d: got %b expected %b",
                         i, ld, k, {timer_reset[i], act_of(i)}, exp_q[k]);
            end
            total++;
            if (load[i] !== 2'(ld)) begin
                bad++;
                $display("FAIL load_hold[%0d] cycle %0d: got %0d expected %0d", i, k, load[i], ld);
            end
            start[i] = (k == exp_q.size() - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            load_sel[i] = 2'($urandom_range(0, 3));
            tick();
        end
        total++;
        if ({done[i], act_of(i), timer_reset[i], fault[i]} !== 8'b1_00000_0_0) begin
            bad++;
            $display("FAIL done_entry[%0d] at cycle %0d: got %b expected %b",
                     i, exp_q.size(), {done[i], act_of(i), timer_reset[i], fault[i]}, 8'b1_00000_0_0);
        end
        hold = $urandom_range(1, 4);
        repeat (hold) begin
            tick();
            total++;
            if ({done[i], act_of(i)} !== 6'b1_00000) begin
                bad++;
                $display("FAIL done_hold[%0d]: got %b expected %b", i, {done[i], act_of(i)}, 6'b1_00000);
            end
        end
        start[i] = 1'b0;
        tick();
        total++;
        if ({done[i], act_of(i), timer_reset[i]} !== 7'b0) begin
            bad++;
            $display("FAIL done_exit[%0d]: got %b expected %b", i, {done[i], act_of(i), timer_reset[i]}, 7'b0);
        end
        tick();
        total++;
        if ({done[i], act_of(i), timer_reset[i]} !== 7'b0) begin
            bad++;
            $display("FAIL idle_stay[%0d]: got %b expected %b", i, {done[i], act_of(i), timer_reset[i]}, 7'b0);
        end
    endtask

    task automatic test_abort();
        int ld, last;
        ld = $urandom_range(0, 2);
        build(1, ld);
        last = 3 + 4 + (2 << ld) + 2 - 1;
        start[0] = 1'b1;
        load_sel[0] = 2'(ld);
        tick();
        start[0] = 1'b0;
        for (int k = 0; k <= last; k++) begin
            total++;
            if ({timer_reset[0], act_of(0)} !== exp_q[k]) begin
                bad++;
                $display("FAIL abort_pre cycle %0d: got %b expected %b", k, {timer_reset[0], act_of(0)}, exp_q[k]);
            end
            if (k == last) abort[0] = 1'b1;
            tick();
        end
        abort[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({timer_reset[0], act_of(0)} !== {(k == 0), A_ABORT}) begin
                bad++;
                $display("FAIL abort_phase cycle %0d: got %b expected %b",
                         k, {timer_reset[0], act_of(0)}, {(k == 0), A_ABORT});
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({timer_reset[0], act_of(0), done[0], fault[0]} !== 8'b0) begin
                bad++;
                $display("FAIL abort_idle cycle %0d: got %b expected %b",
                         k, {timer_reset[0], act_of(0), done[0], fault[0]}, 8'b0);
            end
            abort[0] = 1'($urandom_range(0, 1));
            tick();
        end
        abort[0] = 1'b0;
    endtask

    task automatic test_watchdog();
        int ld;
        ld = $urandom_range(0, 2);
        sup_tf[0] = 1'b1;
        start[0] = 1'b1;
        load_sel[0] = 2'(ld);
        tick();
        start[0] = 1'b0;
        for (int k = 0; k < 3 + WDOG; k++) begin
            total++;
            if ({timer_reset[0], act_of(0), fault[0]} !==
                {(k == 0) || (k == 3), (k < 3) ? A_LOCK : A_FILL, 1'b0}) begin
                bad++;
                $display("FAIL wdog_pre cycle %0d: got %b expected %b", k,
                         {timer_reset[0], act_of(0), fault[0]},
                         {(k == 0) || (k == 3), (k < 3) ? A_LOCK : A_FILL, 1'b0});
            end
            tick();
        end
        total++;
        if ({fault[0], done[0], act_of(0), timer_reset[0]} !== 8'b1_0_00000_0) begin
            bad++;
            $display("FAIL wdog_fault: got %b expected %b", {fault[0], done[0], act_of(0), timer_reset[0]}, 8'b10000000);
        end
        repeat (6) begin
            start[0] = 1'($urandom_range(0, 1));
            abort[0] = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({fault[0], done[0], act_of(0)} !== 7'b1_0_00000) begin
                bad++;
                $display("FAIL fault_sticky: got %b expected %b", {fault[0], done[0], act_of(0)}, 7'b1000000);
            end
        end
        sup_tf[0] = 1'b0; start[0] = 1'b0; abort[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (all_out(0) !== 10'b0) begin
            bad++;
            $display("FAIL fault_clear: got %b expected %b", all_out(0), 10'b0);
        end
        tick();
    endtask

    task automatic test_reset_mid_spin();
        int ld, cut;
        ld = $urandom_range(0, 2);
        build(1, ld);
        cut = $urandom_range(exp_q.size() - 10, exp_q.size() - 1);
        start[0] = 1'b1;
        load_sel[0] = 2'(ld);
        tick();
        start[0] = 1'b0;
        for (int k = 0; k <= cut; k++) begin
            total++;
            if ({timer_reset[0], act_of(0)} !== exp_q[k]) begin
                bad++;
                $display("FAIL spin_pre cycle %0d: got %b expected %b", k, {timer_reset[0], act_of(0)}, exp_q[k]);
            end
            if (k == cut) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        total++;
        if (all_out(0) !== 10'b0) begin
            bad++;
            $display("FAIL reset_mid_spin: got %b expected %b", all_out(0), 10'b0);
        end
        tick();
        total++;
        if (all_out(0) !== 10'b0) begin
            bad++;
            $display("FAIL reset_mid_spin_idle: got %b expected %b", all_out(0), 10'b0);
        end
    endtask

    task automatic test_back_to_back();
        int i;
        repeat (4) begin
            i = $urandom_range(0, 1);
            test_normal(i, (i == 0) ? 1 : 0, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_illegal_load();
        test_normal(0, 1, 0);
        test_normal(0, 1, 2);
        test_abort();
        test_watchdog();
        test_reset_mid_spin();
        test_normal(1, 0, 0);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
